// File: rtl/exu_pkg.sv
// Shared types for the execute-stage result buffer: entry record and buffer state.
package exu_pkg;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] pc;
  } exu_res_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } exu_buf_state_e;

endpackage

// File: rtl/exu_res_buf.sv
// Two-entry skid buffer between execute and memory stages.
// Optional result forwarding lookup is enabled by defining EXU_RES_FWD_EN.
//
// state | meaning
// EMPTY | no entry held, out_valid low
// ONE   | main holds the head entry
// TWO   | main is head, skid holds the younger entry; input stalled
module exu_res_buf
  import exu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_result,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  input  logic [63:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic [63:0] out_pc,
  input  logic        flush
`ifdef EXU_RES_FWD_EN
  ,
  input  logic [4:0]  fwd_rs,
  output logic        fwd_hit,
  output logic [63:0] fwd_data
`endif
);

  exu_buf_state_e state_q, state_d;
  exu_res_t       main_q, main_d;
  exu_res_t       skid_q, skid_d;
  exu_res_t       in_entry;
  logic           in_fire;
  logic           out_fire;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // x0 is never written, so the enable is dropped at capture time.
  always_comb begin
    in_entry.result = in_result;
    in_entry.rd     = in_rd;
    in_entry.wen    = in_wen & (in_rd != 5'd0);
    in_entry.pc     = in_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            skid_d  = in_entry;
            state_d = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_result = '0;
    out_rd     = '0;
    out_wen    = 1'b0;
    out_pc     = '0;
    if (out_valid) begin
      out_result = main_q.result;
      out_rd     = main_q.rd;
      out_wen    = main_q.wen;
      out_pc     = main_q.pc;
    end
  end

`ifdef EXU_RES_FWD_EN
  // Skid is the younger entry, so it wins over main on a double match.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rs != 5'd0) begin
      if (state_q == TWO && skid_q.wen && skid_q.rd == fwd_rs) begin
        fwd_hit  = 1'b1;
        fwd_data = skid_q.result;
      end else if (state_q != EMPTY && main_q.wen && main_q.rd == fwd_rs) begin
        fwd_hit  = 1'b1;
        fwd_data = main_q.result;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exu_res_buf.sv
// Directed bench for exu_res_buf: vector table plus multi-cycle corner sequences.
module tb_exu_res_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [63:0] out_pc;
  logic        flush;
`ifdef EXU_RES_FWD_EN
  logic [4:0]  fwd_rs;
  logic        fwd_hit;
  logic [63:0] fwd_data;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exu_res_buf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_rd      (in_rd),
    .in_wen     (in_wen),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_wen    (out_wen),
    .out_pc     (out_pc),
    .flush      (flush)
`ifdef EXU_RES_FWD_EN
    ,
    .fwd_rs     (fwd_rs),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
`endif
  );

  typedef struct {
    logic        iv;
    logic [63:0] res;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] pc;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic        e_ir;
    logic [63:0] e_res;
    logic [4:0]  e_rd;
    logic        e_wen;
    logic [63:0] e_pc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [63:0] res, input logic [4:0] rd,
                      input logic wen, input logic [63:0] pc, input logic ordy,
                      input logic fl);
    @(negedge clk);
    in_valid  = iv;
    in_result = res;
    in_rd     = rd;
    in_wen    = wen;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic ov, input logic ir,
                         input logic [63:0] res, input logic [4:0] rd,
                         input logic wen, input logic [63:0] pc);
    chk({name, ".out_valid"},  {63'd0, out_valid}, {63'd0, ov});
    chk({name, ".in_ready"},   {63'd0, in_ready},  {63'd0, ir});
    chk({name, ".out_result"}, out_result, res);
    chk({name, ".out_rd"},     {59'd0, out_rd},  {59'd0, rd});
    chk({name, ".out_wen"},    {63'd0, out_wen}, {63'd0, wen});
    chk({name, ".out_pc"},     out_pc, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         iv  res                      rd     wen   pc           ordy  fl    ov    ir    e_res                    e_rd   e_wen e_pc
    vecs[0] = '{1'b1, 64'hFFFF_FFFF_8000_0000, 5'd5, 1'b1, 64'h1000, 1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 5'd5, 1'b1, 64'h1000};
    vecs[1] = '{1'b0, 64'h0,   5'd0, 1'b0, 64'h0,    1'b1, 1'b0, 1'b0, 1'b1, 64'h0,   5'd0, 1'b0, 64'h0};
    vecs[2] = '{1'b1, 64'hA,   5'd1, 1'b1, 64'h2000, 1'b0, 1'b0, 1'b1, 1'b1, 64'hA,   5'd1, 1'b1, 64'h2000};
    vecs[3] = '{1'b1, 64'hB,   5'd2, 1'b1, 64'h2004, 1'b0, 1'b0, 1'b1, 1'b0, 64'hA,   5'd1, 1'b1, 64'h2000};
    vecs[4] = '{1'b1, 64'hC,   5'd3, 1'b1, 64'h2008, 1'b0, 1'b0, 1'b1, 1'b0, 64'hA,   5'd1, 1'b1, 64'h2000};
    vecs[5] = '{1'b0, 64'h0,   5'd0, 1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b1, 64'hB,   5'd2, 1'b1, 64'h2004};
    vecs[6] = '{1'b0, 64'h0,   5'd0, 1'b0, 64'h0,    1'b1, 1'b0, 1'b0, 1'b1, 64'h0,   5'd0, 1'b0, 64'h0};
    vecs[7] = '{1'b1, 64'h77,  5'd0, 1'b1, 64'h3000, 1'b0, 1'b0, 1'b1, 1'b1, 64'h77,  5'd0, 1'b0, 64'h3000};
    vecs[8] = '{1'b0, 64'h0,   5'd0, 1'b0, 64'h0,    1'b1, 1'b0, 1'b0, 1'b1, 64'h0,   5'd0, 1'b0, 64'h0};

    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_rd = '0; in_wen = 1'b0;
    in_pc = '0; out_ready = 1'b0; flush = 1'b0;
`ifdef EXU_RES_FWD_EN
    fwd_rs = 5'd0;
`endif
    #12;
    chk_out("reset", 1'b0, 1'b1, 64'h0, 5'd0, 1'b0, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].iv, vecs[i].res, vecs[i].rd, vecs[i].wen, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
      chk_out($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_res,
              vecs[i].e_rd, vecs[i].e_wen, vecs[i].e_pc);
    end

    // Back-to-back streaming: a new head every cycle, never backpressured.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 64'h100 + 64'(i), 5'(i % 31 + 1), 1'b1, 64'h4000 + 64'(4 * i), 1'b1, 1'b0);
      chk_out($sformatf("stream%0d", i), 1'b1, 1'b1, 64'h100 + 64'(i),
              5'(i % 31 + 1), 1'b1, 64'h4000 + 64'(4 * i));
    end
    step(1'b0, 64'h0, 5'd0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk_out("stream_drain", 1'b0, 1'b1, 64'h0, 5'd0, 1'b0, 64'h0);

    // Flush while full with a concurrent push attempt.
    step(1'b1, 64'h51, 5'd4, 1'b1, 64'h5000, 1'b0, 1'b0);
    step(1'b1, 64'h52, 5'd6, 1'b1, 64'h5004, 1'b0, 1'b0);
    chk_out("flush_pre", 1'b1, 1'b0, 64'h51, 5'd4, 1'b1, 64'h5000);
    step(1'b1, 64'h53, 5'd7, 1'b1, 64'h5008, 1'b0, 1'b1);
    chk_out("flush", 1'b0, 1'b1, 64'h0, 5'd0, 1'b0, 64'h0);
    step(1'b0, 64'h0, 5'd0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk_out("flush_after", 1'b0, 1'b1, 64'h0, 5'd0, 1'b0, 64'h0);

    // Flush from ONE with a push: the pushed entry must also be discarded.
    step(1'b1, 64'h61, 5'd8, 1'b1, 64'h6000, 1'b0, 1'b0);
    step(1'b1, 64'h62, 5'd9, 1'b1, 64'h6004, 1'b1, 1'b1);
    chk_out("flush_one", 1'b0, 1'b1, 64'h0, 5'd0, 1'b0, 64'h0);

`ifdef EXU_RES_FWD_EN
    step(1'b1, 64'h11, 5'd3, 1'b1, 64'h7000, 1'b0, 1'b0);
    step(1'b1, 64'h22, 5'd3, 1'b1, 64'h7004, 1'b0, 1'b0);
    fwd_rs = 5'd3; #1;
    chk("fwd_hit_rs3",  {63'd0, fwd_hit}, 64'd1);
    chk("fwd_data_rs3", fwd_data, 64'h22);
    fwd_rs = 5'd0; #1;
    chk("fwd_hit_rs0",  {63'd0, fwd_hit}, 64'd0);
    chk("fwd_data_rs0", fwd_data, 64'h0);
    fwd_rs = 5'd4; #1;
    chk("fwd_hit_rs4",  {63'd0, fwd_hit}, 64'd0);
    step(1'b0, 64'h0, 5'd0, 1'b0, 64'h0, 1'b0, 1'b1);
    fwd_rs = 5'd3; #1;
    chk("fwd_hit_empty", {63'd0, fwd_hit}, 64'd0);
    fwd_rs = 5'd0;
`endif

    // Async reset while TWO, between edges.
    step(1'b1, 64'h81, 5'd10, 1'b1, 64'h8000, 1'b0, 1'b0);
    step(1'b1, 64'h82, 5'd11, 1'b1, 64'h8004, 1'b0, 1'b0);
    chk_out("rst_pre", 1'b1, 1'b0, 64'h81, 5'd10, 1'b1, 64'h8000);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", 1'b0, 1'b1, 64'h0, 5'd0, 1'b0, 64'h0);
`ifdef EXU_RES_FWD_EN
    chk("rst_fwd_hit", {63'd0, fwd_hit}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 64'h91, 5'd12, 1'b1, 64'h9000, 1'b0, 1'b0);
    chk_out("rst_after", 1'b1, 1'b1, 64'h91, 5'd12, 1'b1, 64'h9000);
    step(1'b0, 64'h0, 5'd0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk_out("rst_drain", 1'b0, 1'b1, 64'h0, 5'd0, 1'b0, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exu_res_buf.md
EXU_RES_BUF -- requirements
Module: exu_res_buf

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: in_valid  input  1  execute-stage result valid (ALU/shifter output).
REQ-004 SHALL: in_ready  output  1  buffer can accept an entry this cycle.
REQ-005 SHALL: in_result  input  64  result, already sign-extended for W-type ops.
REQ-006 SHALL: in_rd  input  5  destination register index.
REQ-007 SHALL: in_wen  input  1  register write enable.
REQ-008 SHALL: in_pc  input  64  PC of the producing instruction.
REQ-009 SHALL: out_valid / out_ready  output / input  1 each  memory-stage handshake.
REQ-010 SHALL: out_result 64, out_rd 5, out_wen 1, out_pc 64  outputs  the head entry.
REQ-011 SHALL: flush  input  1  discard all entries (redirect/trap).
REQ-012 SHALL: fwd_rs  input  5;  fwd_hit  output  1;  fwd_data  output  64  (present only with EXU_RES_FWD_EN).

Function
REQ-013 SHALL: two-entry skid buffer, entries "main" (head, drives out_*) and "skid"; in_fire = in_valid&in_ready; out_fire = out_valid&out_ready.
REQ-014 SHALL: states EMPTY, ONE (main valid), TWO (main+skid valid), encoded from flops.
REQ-015 SHALL: in_ready = (state != TWO), driven from state flops only; no combinational path from out_ready to in_ready.
REQ-016 SHALL: out_valid = (state != EMPTY); out_* = main fields, zero when EMPTY.
REQ-017 SHALL: EMPTY: in_fire -> main<=in, ONE; else stay.
REQ-018 SHALL: ONE: in_fire&out_fire -> main<=in, ONE; in_fire only -> skid<=in, TWO; out_fire only -> EMPTY.
REQ-019 SHALL: TWO: out_fire -> main<=skid, ONE; else hold (no input accepted).
REQ-020 SHALL: latency in->out one cycle when EMPTY; order strictly FIFO; no entry dropped or duplicated.
REQ-021 SHALL: entry captured with in_rd==0 stored with wen=0.
REQ-022 SHALL: flush has priority: next state EMPTY, any simultaneous in_fire/out_fire discarded for state update (out_fire in the flush cycle still counts as consumed downstream).
REQ-023 SHALL: held entries stable while out_valid&!out_ready.

Reset
REQ-024 SHALL: rst_n low asynchronously forces EMPTY, all entry fields 0, out_valid=0, in_ready=1, fwd_hit=0.
REQ-025 SHALL: reset asserted mid-transfer loses all entries; first in_fire after release behaves as from EMPTY.

Configuration
REQ-026 SHALL: with EXU_RES_FWD_EN defined, fwd_hit=1 when a valid entry has wen=1 and rd==fwd_rs!=0; fwd_data = youngest match (skid before main); combinational from flops; no hit -> fwd_hit=0, fwd_data=0.
REQ-027 SHALL: without EXU_RES_FWD_EN, fwd_* ports and match logic absent; all other behaviour identical.

Structure
REQ-028 SHALL: package exu_pkg holds typedef exu_res_t {result 64, rd 5, wen 1, pc 64} and enum exu_buf_state_e {EMPTY, ONE, TWO}.
REQ-029 SHALL: no sub-module; forwarding match inline.

Verification
REQ-030 SHALL: reset, out_ready=1, push result=0xFFFF_FFFF_8000_0000 rd=5 -> out_valid next cycle with same data, then EMPTY.
REQ-031 SHALL: out_ready=0, push A(rd=1), B(rd=2) -> state TWO, in_ready=0; push C ignored; release out_ready -> A, B in order, in_ready=1 after A.
REQ-032 SHALL: state ONE, in_fire&out_fire every cycle for 10 pushes -> throughput 1/cycle, never TWO.
REQ-033 SHALL: state TWO, flush with in_valid=1 -> EMPTY next cycle, pushed entry absent.
REQ-034 SHALL: push rd=0 wen=1 -> out_wen=0; with EXU_RES_FWD_EN, main rd=3=0x11, skid rd=3=0x22, fwd_rs=3 -> fwd_hit=1, fwd_data=0x22; fwd_rs=0 -> fwd_hit=0.
REQ-035 SHALL: rst_n low while TWO between clock edges -> out_valid=0 immediately, in_ready=1.
